ex_muldiv_ctrl: RTL



---
 rtl/md_pkg.sv | 23 ++
 rtl/md_iter_core.sv | 59 +++++
 rtl/ex_muldiv_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes, FSM states, width.
// No logic; constants only.
// Imported by ex_muldiv_ctrl and md_iter_core.
package md_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Double-width accumulator doing one shift-add multiply or restoring-divide step per enable.
// Latency: one step per cycle with step high; load takes effect on the next edge.
// No backpressure: the controller owns sequencing and simply withholds step.
module md_iter_core
    import md_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [XLEN_P-1:0]     ld_lo,
    input  logic [XLEN_P-1:0]     ld_opnd,
    output logic [2*XLEN_P-1:0]   acc
);

    logic [XLEN_P-1:0]   opnd;
    logic [2*XLEN_P-1:0] acc_nxt;
    logic [XLEN_P:0]     mul_sum;
    logic [XLEN_P:0]     rem_sh;
    logic [XLEN_P-1:0]   diff_lo;
    logic                rem_ge;

    // Multiply: acc = {partial_hi, multiplier}, consuming the multiplier LSB-first.
    // Divide: acc = {remainder, quotient}, shifted left each step.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN_P-1:XLEN_P]};
        if (acc[0]) begin
            mul_sum = {1'b0, acc[2*XLEN_P-1:XLEN_P]} + {1'b0, opnd};
        end
        rem_sh  = acc[2*XLEN_P-1:XLEN_P-1];
        rem_ge  = (rem_sh >= {1'b0, opnd});
        diff_lo = rem_sh[XLEN_P-1:0] - opnd;
        if (is_div) begin
            if (rem_ge) begin
                acc_nxt = {diff_lo, acc[XLEN_P-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN_P-1:0], acc[XLEN_P-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc[XLEN_P-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{XLEN_P{1'b0}}, ld_lo};
            opnd <= ld_opnd;
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the EX ALU; stalls the front end while busy.
// Latency: result valid 33 edges after accept (1 edge for divide-by-zero / signed overflow).
// Holds result and out_valid in DONE until out_ready; accepts only in IDLE; flush aborts.
module ex_muldiv_ctrl
    import md_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [XLEN_P-1:0] rs1_data,
    input  logic [XLEN_P-1:0] rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN_P-1:0] result,
    output logic              busy,
    output logic              stall
);

    localparam int CNT_W = $clog2(XLEN_P);

    md_state_t            state;
    logic [2:0]           op_q;
    logic                 sa_q;
    logic                 sb_q;
    logic [CNT_W-1:0]     cnt;
    logic                 fin;
    logic [XLEN_P-1:0]    result_q;

    logic                 accept;
    logic                 is_div_in;
    logic                 sa_in;
    logic                 sb_in;
    logic [XLEN_P-1:0]    a_mag;
    logic [XLEN_P-1:0]    b_mag;
    logic                 div0;
    logic                 ovf;
    logic                 special;
    logic [XLEN_P-1:0]    spec_res;
    logic                 step;
    logic [2*XLEN_P-1:0]  acc;
    logic [2*XLEN_P-1:0]  prod;
    logic [XLEN_P-1:0]    fix_res;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign result    = result_q;
    assign stall     = (in_valid & in_ready) | (busy & ~(out_valid & out_ready));

    assign accept    = in_valid & in_ready & ~flush;
    assign is_div_in = op[2];
    assign sa_in     = rs1_data[XLEN_P-1] &
                       ((op == MD_MULH) | (op == MD_MULHSU) | (op == MD_DIV) | (op == MD_REM));
    assign sb_in     = rs2_data[XLEN_P-1] &
                       ((op == MD_MULH) | (op == MD_DIV) | (op == MD_REM));
    assign a_mag     = sa_in ? -rs1_data : rs1_data;
    assign b_mag     = sb_in ? -rs2_data : rs2_data;

    assign div0      = is_div_in & (rs2_data == '0);
    assign ovf       = ((op == MD_DIV) | (op == MD_REM)) &
                       (rs1_data == {1'b1, {(XLEN_P-1){1'b0}}}) & (rs2_data == '1);
    assign special   = div0 | ovf;

    // op[1] separates remainder from quotient; on overflow the dividend is the quotient.
    always_comb begin
        spec_res = '0;
        if (div0) begin
            spec_res = op[1] ? rs1_data : '1;
        end else begin
            spec_res = op[1] ? '0 : rs1_data;
        end
    end

    always_comb begin
        prod    = (sa_q ^ sb_q) ? -acc : acc;
        fix_res = (op_q == MD_MUL) ? prod[XLEN_P-1:0] : prod[2*XLEN_P-1:XLEN_P];
        if (op_q[2]) begin
            if (op_q[1]) begin
                fix_res = sa_q ? -acc[2*XLEN_P-1:XLEN_P] : acc[2*XLEN_P-1:XLEN_P];
            end else begin
                fix_res = (sa_q ^ sb_q) ? -acc[XLEN_P-1:0] : acc[XLEN_P-1:0];
            end
        end
    end

    assign step = (state == S_CALC) & ~fin & ~flush;

    md_iter_core #(
        .XLEN_P (XLEN_P)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    (step),
        .is_div  (op_q[2]),
        .ld_lo   (is_div_in ? a_mag : b_mag),
        .ld_opnd (is_div_in ? b_mag : a_mag),
        .acc     (acc)
    );

    // fin marks that the last step has landed; the following edge applies sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt      <= '0;
            fin      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        sa_q <= sa_in;
                        sb_q <= sb_in;
                        fin  <= 1'b0;
                        if (special) begin
                            result_q <= spec_res;
                            state    <= S_DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN_P - 1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        fin   <= 1'b0;
                        state <= S_IDLE;
                    end else if (fin) begin
                        fin      <= 1'b0;
                        result_q <= fix_res;
                        state    <= S_DONE;
                    end else if (cnt == '0) begin
                        fin <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
